// File: rtl/sort_pkg.sv
// Shared types and helpers for the sort bank readout path.
package sort_pkg;

    localparam int unsigned DATAWIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index counter width; a single-element bank still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sort_unload_if.sv
// Valid/ready word stream carrying one bank element plus its index.
interface sort_unload_if #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned IDXW      = 3
);
    logic [DATAWIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [IDXW-1:0]      out_idx;
    logic                 out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_idx,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/sort_elem_mux.sv
// Combinational select of one element from a flattened register bank.
module sort_elem_mux #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned NUM_ELEMS = 8,
    parameter int unsigned IDXW      = 3
) (
    input  logic [NUM_ELEMS*DATAWIDTH-1:0] i_vec,
    input  logic [IDXW-1:0]                i_idx,
    output logic [DATAWIDTH-1:0]           o_data_c
);

    always_comb begin
        o_data_c = '0;
        for (int i = 0; i < int'(NUM_ELEMS); i++) begin
            if (i_idx == IDXW'(i)) begin
                o_data_c = i_vec[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

endmodule

// File: rtl/sort_unload.sv
// Captures a sorted bank on ld and drains it word by word in index order.
// Optional monotonicity checker enabled by defining SORT_UNLOAD_CHECK_EN.
module sort_unload
    import sort_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DATAWIDTH_DEF,
    parameter int unsigned NUM_ELEMS = 8,
    parameter int unsigned IDXW      = idx_width(NUM_ELEMS)
) (
    input  logic                           clk,
    input  logic                           clr_n,
    input  logic                           ld,
    input  logic [NUM_ELEMS*DATAWIDTH-1:0] in_vec,
`ifdef SORT_UNLOAD_CHECK_EN
    output logic                           err,
`endif
    sort_unload_if.master                  out_if,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned    BUFW     = NUM_ELEMS * DATAWIDTH;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_ELEMS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [BUFW-1:0]       r_buf;
    logic [BUFW-1:0]       w_buf_nxt;
    logic [IDXW-1:0]       r_idx;
    logic [IDXW-1:0]       w_idx_nxt;
    logic [DATAWIDTH-1:0]  r_data;
    logic [DATAWIDTH-1:0]  w_sel_data;
    logic                  r_valid;
    logic                  r_last;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_load;
    logic                  w_xfer;

    assign w_xfer = r_valid && out_if.out_ready;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (ld) begin
                    w_load      = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (w_xfer) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_idx_nxt = r_idx + IDXW'(1);
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_buf_nxt = w_load ? in_vec : r_buf;

    // Select from the next-cycle bank/index so out_data is registered with zero extra latency.
    sort_elem_mux #(
        .DATAWIDTH (DATAWIDTH),
        .NUM_ELEMS (NUM_ELEMS),
        .IDXW      (IDXW)
    ) u_elem_mux (
        .i_vec    (w_buf_nxt),
        .i_idx    (w_idx_nxt),
        .o_data_c (w_sel_data)
    );

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_buf   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_buf   <= w_buf_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_sel_data;
            r_valid <= (w_state_nxt == SEND);
            r_last  <= (w_state_nxt == SEND) && (w_idx_nxt == LAST_IDX);
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    assign out_if.out_data  = r_data;
    assign out_if.out_valid = r_valid;
    assign out_if.out_idx   = r_idx;
    assign out_if.out_last  = r_last;
    assign busy             = r_busy;
    assign done             = r_done;

`ifdef SORT_UNLOAD_CHECK_EN
    logic [DATAWIDTH-1:0] r_prev;
    logic                 r_err;

    // Sticky flag for any descending step between consecutive transferred words.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_prev <= '0;
            r_err  <= 1'b0;
        end else if (w_load) begin
            r_err <= 1'b0;
        end else if (w_xfer) begin
            r_prev <= r_data;
            if ((r_idx != '0) && (r_data < r_prev)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`endif

endmodule
